// File: rtl/axi_burst_read_responder.sv
// AXI read-only responder serving FIXED/INCR/WRAP bursts from a 1-cycle synchronous word memory.
// Latency: AR handshake in cycle T, first mem_en in T+1, first rvalid in T+3, then one beat per cycle.
// Backpressure: a 2-entry output FIFO plus one in-flight slot absorbs rready stalls without bubbles.
// Ports: clk/rst (sync, active-high); axi_req/axi_req_arid (AR + rready in);
//        axi_resp/axi_resp_rid (arready + R channel out); mem_en/mem_addr/mem_rdata (word memory);
//        busy (burst in progress).

package axi_burst_read_responder_pkg;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_req_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } axi_resp_t;

endpackage

module axi_burst_read_responder
  import axi_burst_read_responder_pkg::*;
#(
  parameter int          BUS_WIDTH = 4,
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  axi_req_t                     axi_req,
  input  logic [BUS_WIDTH-1:0]         axi_req_arid,
  output axi_resp_t                    axi_resp,
  output logic [BUS_WIDTH-1:0]         axi_resp_rid,
  output logic                         mem_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [31:0]                  mem_rdata,
  output logic                         busy
);

  localparam int AW = $clog2(MEM_DEPTH);
  // Byte offset inside the window; wraps naturally modulo the window size.
  localparam int OW = AW + 2;
  localparam logic [32:0] WIN_BYTES = 33'(4 * MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  state_t state_q, state_nxt;

  // Captured burst context
  logic [OW-1:0]        off_q;
  logic [7:0]           len_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [BUS_WIDTH-1:0] id_q;
  logic [1:0]           err_q;
  logic [8:0]           issues_left_q;

  // One memory read in flight: its data lands in the FIFO the following cycle
  logic       inflight_q;
  logic [1:0] inf_err_q;
  logic       inf_last_q;

  // 2-entry output FIFO
  rbeat_t     fifo_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;

  logic          ar_hs, issue, push, pop, fifo_vld;
  logic [2:0]    occ;
  logic [32:0]   ar_diff;
  logic          ar_in_win;
  logic [1:0]    ar_err;
  logic [OW-1:0] step, wrap_mask, off_inc, off_nxt;
  rbeat_t        head, push_beat;

  // Write-channel and unused request fields are deliberately ignored.
  logic unused_req;
  assign unused_req = ^{axi_req.awvalid, axi_req.awaddr, axi_req.awlen, axi_req.awsize,
                        axi_req.awburst, axi_req.wvalid, axi_req.wdata, axi_req.wstrb,
                        axi_req.wlast, axi_req.bready};

  assign ar_hs    = axi_req.arvalid && (state_q == IDLE);
  assign head     = fifo_q[rd_ptr_q];
  assign fifo_vld = (count_q != 2'd0);
  assign pop      = fifo_vld && axi_req.rready;
  assign push     = inflight_q;

  // Occupancy the FIFO will have after this cycle's pop, counting the in-flight beat;
  // issuing only below 2 guarantees a landing slot for every read.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == BURST) && (issues_left_q != 9'd0) && (occ < 3'd2);

  // 33-bit difference: addresses below BASE_ADDR borrow into bit 32 and fail the window test.
  assign ar_diff   = {1'b0, axi_req.araddr} - {1'b0, BASE_ADDR};
  assign ar_in_win = (ar_diff < WIN_BYTES);
  assign ar_err    = !ar_in_win            ? RESP_DECERR :
                     (axi_req.arsize > 3'd2) ? RESP_SLVERR : RESP_OKAY;

  assign step      = OW'(1) << size_q;
  assign wrap_mask = ((OW'(len_q) + OW'(1)) << size_q) - OW'(1);
  assign off_inc   = off_q + step;

  always_comb begin
    off_nxt = off_inc;
    case (burst_q)
      2'b00:   off_nxt = off_q;
      2'b10:   off_nxt = (off_q & ~wrap_mask) | (off_inc & wrap_mask);
      default: off_nxt = off_inc;  // INCR and the reserved encoding
    endcase
  end

  // Errored beats keep the memory idle but still occupy a pipeline slot.
  assign mem_en   = issue && (err_q == RESP_OKAY);
  assign mem_addr = off_q[OW-1:2];

  assign push_beat.dat  = (inf_err_q == RESP_OKAY) ? mem_rdata : 32'd0;
  assign push_beat.resp = inf_err_q;
  assign push_beat.last = inf_last_q;

  assign axi_resp_rid = id_q;
  assign busy         = (state_q == BURST);

  always_comb begin
    state_nxt        = state_q;
    axi_resp         = '0;
    axi_resp.arready = (state_q == IDLE);
    axi_resp.rvalid  = fifo_vld;
    axi_resp.rdata   = head.dat;
    axi_resp.rresp   = head.resp;
    axi_resp.rlast   = head.last;
    case (state_q)
      IDLE:    if (axi_req.arvalid) state_nxt = BURST;
      BURST:   if (pop && head.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      off_q         <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      id_q          <= '0;
      err_q         <= RESP_OKAY;
      issues_left_q <= '0;
      inflight_q    <= 1'b0;
      inf_err_q     <= RESP_OKAY;
      inf_last_q    <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      state_q <= state_nxt;

      if (ar_hs) begin
        off_q         <= ar_diff[OW-1:0];
        len_q         <= axi_req.arlen;
        size_q        <= axi_req.arsize;
        burst_q       <= axi_req.arburst;
        id_q          <= axi_req_arid;
        err_q         <= ar_err;
        issues_left_q <= {1'b0, axi_req.arlen} + 9'd1;
      end else if (issue) begin
        off_q         <= off_nxt;
        issues_left_q <= issues_left_q - 9'd1;
      end

      inflight_q <= issue;
      if (issue) begin
        inf_err_q  <= err_q;
        inf_last_q <= (issues_left_q == 9'd1);
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= push_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count_q == 2'd2));
  end

endmodule

// File: tb/tb_axi_burst_read_responder.sv
module tb_axi_burst_read_responder;
  import axi_burst_read_responder_pkg::*;

  localparam int          BW    = 4;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h1fc0_0000;

  logic            clk = 1'b0;
  logic            rst;
  axi_req_t        req;
  logic [BW-1:0]   arid;
  axi_resp_t       resp;
  logic [BW-1:0]   rid;
  logic            mem_en;
  logic [11:0]     mem_addr;
  logic [31:0]     mem_rdata;
  logic            busy;

  logic        arvalid, rready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  always #5 clk = ~clk;

  always_comb begin
    req         = '0;
    req.arvalid = arvalid;
    req.araddr  = araddr;
    req.arlen   = arlen;
    req.arsize  = arsize;
    req.arburst = arburst;
    req.rready  = rready;
  end

  axi_burst_read_responder #(.BUS_WIDTH(BW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .axi_req(req), .axi_req_arid(arid), .axi_resp(resp),
    .axi_resp_rid(rid), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected R beats
  typedef struct {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
    logic [BW-1:0] id;
    int            nmem;
  } beat_t;
  beat_t sbq[$];

  // Reference model: byte address of each beat from the AXI burst rules, then window lookup.
  task automatic push_expect(input logic [31:0] a, input int len, input int size,
                             input int burst, input logic [BW-1:0] id);
    longint addr, step, region, bound, off, win;
    int     err;
    beat_t  b;
    win    = 4 * DEPTH;
    step   = longint'(1) << size;
    region = (len + 1) * step;
    bound  = (longint'(a) / region) * region;
    if (!(longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + win)) err = 3;
    else if (size > 2) err = 2;
    else err = 0;
    for (int i = 0; i <= len; i++) begin
      case (burst)
        0:       addr = longint'(a);
        2:       addr = bound + ((longint'(a) - bound) + i * step) % region;
        default: addr = longint'(a) + i * step;
      endcase
      off    = (((addr - longint'(BASE)) % win) + win) % win;
      b.data = (err != 0) ? 32'd0 : mem[int'(off / 4)];
      b.resp = 2'(err);
      b.last = (i == len);
      b.id   = id;
      b.nmem = (err != 0) ? 0 : len + 1;
      sbq.push_back(b);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // rready generator: 0 = always ready, 1 = fixed pattern per valid cycle, 2 = random
  int         rmode = 0;
  int         pidx  = 0;
  logic [7:0] pat   = 8'b1110_1001;  // beats see 1,0,0,1,0,1,1,1
  always @(negedge clk) begin
    if (rmode == 0) begin
      rready = 1'b1;
      pidx   = 0;
    end else if (rmode == 1) begin
      rready = (pidx < 8) ? pat[pidx] : 1'b1;
      if (resp.rvalid && pidx < 8) pidx++;
    end else begin
      rready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops and compares each R handshake; tracks memory issue vs pop distance.
  int          men_cnt = 0, issued = 0, popped_ok = 0, max_out = 0, pops_burst = 0;
  int          last_pop_cyc = -10;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_dat;
  always @(negedge clk) begin
    beat_t b;
    #1;
    if (rst) begin
      men_cnt = 0; issued = 0; popped_ok = 0; pops_burst = 0; prev_stall = 1'b0;
    end else begin
      if (mem_en) begin men_cnt++; issued++; end
      if (prev_stall) begin
        chk("hold_rvalid", resp.rvalid, 1);
        chk("hold_rbeat", {resp.rdata, resp.rresp, resp.rlast}, prev_dat);
      end
      if (resp.rvalid && rready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", resp.rvalid, 0);
        end else begin
          b = sbq.pop_front();
          chk("rdata", resp.rdata, b.data);
          chk("rresp", resp.rresp, b.resp);
          chk("rlast", resp.rlast, b.last);
          chk("rid", rid, b.id);
          if (b.resp == 2'b00) popped_ok++;
          pops_burst++;
          if (b.last) begin
            chk("mem_en_count", men_cnt, b.nmem);
            men_cnt = 0; pops_burst = 0; last_pop_cyc = cyc;
          end
        end
      end
      if (issued - popped_ok > max_out) max_out = issued - popped_ok;
      prev_stall = resp.rvalid && !rready;
      prev_dat   = {resp.rdata, resp.rresp, resp.rlast};
    end
  end

  // Presents an AR and holds it until accepted; returns just after the negedge following acceptance.
  task automatic send_ar(input logic [31:0] a, input int len, input int size, input int burst,
                         input logic [BW-1:0] id, output int hs_cyc, output logic hs_busy);
    bit done;
    done = 0; hs_cyc = -1; hs_busy = 1'b1;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = id;
    for (int n = 0; n < 3000 && !done; n++) begin
      #1;
      if (resp.arready) begin
        done = 1; hs_cyc = cyc; hs_busy = busy;
        push_expect(a, len, size, burst, id);
      end
      @(negedge clk);
    end
    arvalid = 1'b0;
    #1;
    chk("ar_accepted", done, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (sbq.size() == 0 && !busy) done = 1;
      else begin @(negedge clk); #1; end
    end
    chk("drain", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          hs, hs2, n;
    logic        hb;
    logic [31:0] a;
    int          len, size, burst, sel;
    int          wexp [4];

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst = 1'b1; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arid = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid", resp.rvalid, 0);
    chk("rst_rlast", resp.rlast, 0);
    chk("rst_rresp", resp.rresp, 0);
    chk("rst_rdata", resp.rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_chan", {resp.awready, resp.wready, resp.bvalid}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_arready", resp.arready, 1);

    // 1: INCR, cycle-exact timing with rready=1
    send_ar(BASE + 32'h10, 7, 2, 1, 4'd5, hs, hb);
    for (int k = 1; k <= 10; k++) begin
      chk("t1_mem_en", mem_en, (k <= 8));
      if (k <= 8) chk("t1_mem_addr", mem_addr, 4 + k - 1);
      chk("t1_rvalid", resp.rvalid, (k >= 3));
      @(negedge clk); #1;
    end
    wait_idle();

    // 2: backpressure pattern
    rmode = 1;
    send_ar(BASE + 32'h10, 7, 2, 1, 4'd5, hs, hb);
    wait_idle();
    rmode = 0;

    // 3: WRAP and FIXED address sequences
    wexp[0] = 6; wexp[1] = 7; wexp[2] = 4; wexp[3] = 5;
    send_ar(BASE + 32'h18, 3, 2, 2, 4'd1, hs, hb);
    for (int k = 0; k < 4; k++) begin
      chk("t3_wrap_mem_en", mem_en, 1);
      chk("t3_wrap_addr", mem_addr, wexp[k]);
      @(negedge clk); #1;
    end
    wait_idle();
    send_ar(BASE + 32'h18, 3, 2, 0, 4'd2, hs, hb);
    for (int k = 0; k < 4; k++) begin
      chk("t3_fixed_mem_en", mem_en, 1);
      chk("t3_fixed_addr", mem_addr, 6);
      @(negedge clk); #1;
    end
    wait_idle();

    // 4: DECERR below the window, SLVERR for arsize=3
    send_ar(BASE - 32'd4, 1, 2, 1, 4'd3, hs, hb);
    wait_idle();
    send_ar(BASE + 32'h20, 3, 3, 1, 4'd4, hs, hb);
    wait_idle();

    // 5: reset after the second beat handshake
    send_ar(BASE + 32'h40, 7, 2, 1, 4'd6, hs, hb);
    n = 0;
    while (pops_burst < 2 && n < 100) begin @(negedge clk); n++; end
    chk("t5_two_beats_seen", (pops_burst >= 2), 1);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk); #1;
    chk("t5_rvalid", resp.rvalid, 0);
    chk("t5_arready", resp.arready, 1);
    @(negedge clk);
    rst = 1'b0;
    send_ar(BASE, 3, 2, 1, 4'd9, hs, hb);
    wait_idle();

    // 6: back-to-back ARs
    send_ar(BASE + 32'h100, 3, 2, 1, 4'd7, hs, hb);
    chk("t6_busy_during", busy, 1);
    send_ar(BASE + 32'h200, 3, 2, 1, 4'd8, hs2, hb);
    chk("t6_accept_cycle", hs2, last_pop_cyc + 1);
    chk("t6_busy_low_at_accept", hb, 0);
    chk("t6_busy_after_accept", busy, 1);
    wait_idle();

    // Randomized bursts under random backpressure, including window edges and errors
    rmode = 2;
    for (int t = 0; t < 40; t++) begin
      burst = $urandom_range(0, 3);
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
      sel   = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
      else if (sel == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
      else if (sel == 2) a = BASE + 32'(4 * DEPTH) - 32'(4 * $urandom_range(1, 8));
      else               a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      a = a & ~((32'd1 << size) - 32'd1);
      send_ar(a, len, size, burst, 4'($urandom_range(0, 15)), hs, hb);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    rmode = 0;

    chk("max_outstanding_le2", (max_out <= 2), 1);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
